// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-side signals of mem_arbiter.
//   p0_* / p1_* : enable/write/addr/data in, ack/data out (per requester)
//   mem_*       : line handshake towards Data_Memory
// Modports: slave = arbiter side, master = requesters + memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              p0_enable_i, p0_write_i, p0_ack_o;
  logic [ADDR_W-1:0] p0_addr_i;
  logic [LINE_W-1:0] p0_data_i, p0_data_o;
  logic              p1_enable_i, p1_write_i, p1_ack_o;
  logic [ADDR_W-1:0] p1_addr_i;
  logic [LINE_W-1:0] p1_data_i, p1_data_o;
  logic              mem_enable_o, mem_write_o, mem_ack_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o, mem_data_i;

  modport slave (
    input  p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
    input  p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
    input  mem_data_i, mem_ack_i,
    output p0_ack_o, p0_data_o, p1_ack_o, p1_data_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
    output p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
    output mem_data_i, mem_ack_i,
    input  p0_ack_o, p0_data_o, p1_ack_o, p1_data_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the Data_Memory line port between port 0 (dcache
// miss/write-back) and port 1 (instruction-fetch refill).
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : mem_arbiter_if.slave (requester + memory handshakes)
//   busy_o       : state != IDLE
//   owner_o      : port of current/last grant
//   timeout_o    : sticky, a transaction spent TIMEOUT cycles in BUSY
// Build option: MEM_ARB_RR_EN selects round-robin on simultaneous requests;
// undefined gives fixed priority to port 0.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mem_arbiter_if.slave bus,
  output logic         busy_o,
  output logic         owner_o,
  output logic         timeout_o
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]        mem_data_q, mem_data_d;
  logic                     owner_q, owner_d, tmo_q, tmo_d, win;
  logic [1:0]               ack_q, ack_d;
  logic [1:0][LINE_W-1:0]   rdat_q, rdat_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
`ifdef MEM_ARB_RR_EN
  logic                     granted_q, granted_d;
`endif

  logic [1:0]               en, wr;
  logic [1:0][ADDR_W-1:0]   addr;
  logic [1:0][LINE_W-1:0]   wdat;

  assign en   = {bus.p1_enable_i, bus.p0_enable_i};
  assign wr   = {bus.p1_write_i,  bus.p0_write_i};
  assign addr = {bus.p1_addr_i,   bus.p0_addr_i};
  assign wdat = {bus.p1_data_i,   bus.p0_data_i};

  always_comb begin
    state_d    = state_q;
    mem_en_d   = mem_en_q;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    owner_d    = owner_q;
    tmo_d      = tmo_q;
    ack_d      = '0;
    rdat_d     = rdat_q;
    cnt_d      = cnt_q;
    // port 0 wins unless only port 1 is asking
    win        = ~en[0];
`ifdef MEM_ARB_RR_EN
    granted_d  = granted_q;
    // both asking: alternate away from the last owner; very first grant goes to port 0
    if (&en) win = granted_q & ~owner_q;
`endif
    case (state_q)
      IDLE: if (|en) begin
        state_d    = BUSY;
        mem_en_d   = 1'b1;
        mem_wr_d   = wr[win];
        mem_addr_d = addr[win];
        mem_data_d = wdat[win];
        owner_d    = win;
        cnt_d      = '0;
`ifdef MEM_ARB_RR_EN
        granted_d  = 1'b1;
`endif
      end
      BUSY: if (bus.mem_ack_i) begin
        state_d         = DONE;
        mem_en_d        = 1'b0;
        ack_d[owner_q]  = 1'b1;
        rdat_d[owner_q] = mem_wr_q ? '0 : bus.mem_data_i;
      end else begin
        // cnt_q = BUSY cycles already completed; flag on the edge that completes the TIMEOUT-th
        if (cnt_q != CNT_W'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(TIMEOUT - 1)) tmo_d = 1'b1;
      end
      // one dead cycle so the winner can drop its enable before the next grant
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      owner_q    <= 1'b0;
      tmo_q      <= 1'b0;
      ack_q      <= '0;
      rdat_q     <= '0;
      cnt_q      <= '0;
`ifdef MEM_ARB_RR_EN
      granted_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mem_en_q   <= mem_en_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      owner_q    <= owner_d;
      tmo_q      <= tmo_d;
      ack_q      <= ack_d;
      rdat_q     <= rdat_d;
      cnt_q      <= cnt_d;
`ifdef MEM_ARB_RR_EN
      granted_q  <= granted_d;
`endif
    end
  end

  assign bus.mem_enable_o = mem_en_q;
  assign bus.mem_write_o  = mem_wr_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_data_q;
  assign bus.p0_ack_o     = ack_q[0];
  assign bus.p1_ack_o     = ack_q[1];
  assign bus.p0_data_o    = rdat_q[0];
  assign bus.p1_data_o    = rdat_q[1];
  assign busy_o           = (state_q != IDLE);
  assign owner_o          = owner_q;
  assign timeout_o        = tmo_q;
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  typedef struct {logic w; logic [31:0] a; logic [255:0] d;} req_t;
  typedef struct {logic p; logic w; logic [31:0] a; logic [255:0] d; logic [255:0] r;} exp_t;

  logic clk_i = 1'b0, rst_i = 1'b1;
  logic busy_o, owner_o, timeout_o;
  logic          req_en [2];
  logic          req_w  [2];
  logic [31:0]   req_a  [2];
  logic [255:0]  req_d  [2];
  logic          mem_hold = 1'b0, mem_force = 1'b0;
  req_t          rq0[$], rq1[$];
  exp_t          exp_q[$];
  logic [255:0]  last_d [2];
  int            checks = 0, failures = 0;

  always #5 clk_i = ~clk_i;

  mem_arbiter_if #(.ADDR_W(32), .LINE_W(256)) bus ();

  mem_arbiter #(.ADDR_W(32), .LINE_W(256), .TIMEOUT(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus),
    .busy_o(busy_o), .owner_o(owner_o), .timeout_o(timeout_o)
  );

  assign bus.p0_enable_i = req_en[0];
  assign bus.p0_write_i  = req_w[0];
  assign bus.p0_addr_i   = req_a[0];
  assign bus.p0_data_i   = req_d[0];
  assign bus.p1_enable_i = req_en[1];
  assign bus.p1_write_i  = req_w[1];
  assign bus.p1_addr_i   = req_a[1];
  assign bus.p1_data_i   = req_d[1];

  function automatic logic [255:0] line_of(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic p, input logic w, input logic [31:0] a, input logic [255:0] d);
    req_t q;
    q.w = w; q.a = a; q.d = d;
    if (p) rq1.push_back(q); else rq0.push_back(q);
  endtask

  task automatic expect_txn(input logic p, input logic w, input logic [31:0] a, input logic [255:0] d);
    exp_t e;
    e.p = p; e.w = w; e.a = a; e.d = d; e.r = w ? '0 : line_of(a);
    exp_q.push_back(e);
  endtask

  task automatic wait_grant();
    int k = 0;
    while (!bus.mem_enable_o && k < 100) begin @(negedge clk_i); k++; end
    check("grant_wait", {255'd0, bus.mem_enable_o}, 256'd1);
  endtask

  task automatic wait_ack(input logic p);
    int k = 0;
    while (!(p ? bus.p1_ack_o : bus.p0_ack_o) && k < 200) begin @(negedge clk_i); k++; end
    check("ack_wait", {255'd0, (k < 200)}, 256'd1);
    @(negedge clk_i);
    check("ack_pulse", {255'd0, (p ? bus.p1_ack_o : bus.p0_ack_o)}, 256'd0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_q.size() != 0 || busy_o) && k < 1000) begin @(negedge clk_i); k++; end
    check("idle_wait", {255'd0, (k < 1000)}, 256'd1);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    last_d[0] = '0; last_d[1] = '0;
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_enable", {255'd0, bus.mem_enable_o}, 256'd0);
    check("rst_mem_write",  {255'd0, bus.mem_write_o}, 256'd0);
    check("rst_mem_addr",   {224'd0, bus.mem_addr_o}, 256'd0);
    check("rst_mem_data",   bus.mem_data_o, 256'd0);
    check("rst_acks",       {254'd0, bus.p1_ack_o, bus.p0_ack_o}, 256'd0);
    check("rst_p0_data",    bus.p0_data_o, 256'd0);
    check("rst_p1_data",    bus.p1_data_o, 256'd0);
    check("rst_status",     {253'd0, busy_o, owner_o, timeout_o}, 256'd0);
  endtask

  // Memory model: ack 10 cycles after enable rises; hold stalls it, force injects a stray ack.
  initial begin
    int cnt = 0;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (bus.mem_enable_o) cnt++; else cnt = 0;
      bus.mem_ack_i  = mem_force | (bus.mem_enable_o & (cnt >= 10) & ~mem_hold);
      bus.mem_data_i = line_of(bus.mem_addr_o);
    end
  end

  // Requesters: hold enable until ack, drop for one cycle, then present the next queued request.
  initial begin
    for (int p = 0; p < 2; p++) begin
      req_en[p] = 1'b0; req_w[p] = 1'b0; req_a[p] = '0; req_d[p] = '0;
    end
    forever begin
      @(negedge clk_i);
      if (req_en[0]) begin
        if (bus.p0_ack_o) begin req_en[0] = 1'b0; if (rq0.size() > 0) void'(rq0.pop_front()); end
      end else if (rq0.size() > 0) begin
        req_en[0] = 1'b1; req_w[0] = rq0[0].w; req_a[0] = rq0[0].a; req_d[0] = rq0[0].d;
      end
      if (req_en[1]) begin
        if (bus.p1_ack_o) begin req_en[1] = 1'b0; if (rq1.size() > 0) void'(rq1.pop_front()); end
      end else if (rq1.size() > 0) begin
        req_en[1] = 1'b1; req_w[1] = rq1[0].w; req_a[1] = rq1[0].a; req_d[1] = rq1[0].d;
      end
    end
  end

  // Scoreboard: compare each grant and each ack against the head expected transaction.
  initial begin
    logic prev_en = 1'b0;
    exp_t e;
    last_d[0] = '0; last_d[1] = '0;
    forever begin
      @(negedge clk_i);
      if (bus.mem_enable_o && !prev_en) begin
        check("grant_expected", {224'd0, 32'(exp_q.size() != 0)}, 256'd1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          check("grant_owner", {255'd0, owner_o}, {255'd0, e.p});
          check("grant_write", {255'd0, bus.mem_write_o}, {255'd0, e.w});
          check("grant_addr",  {224'd0, bus.mem_addr_o}, {224'd0, e.a});
          check("grant_data",  bus.mem_data_o, e.d);
        end
      end
      prev_en = bus.mem_enable_o;
      if (bus.p0_ack_o || bus.p1_ack_o) begin
        check("ack_expected", {224'd0, 32'(exp_q.size() != 0)}, 256'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("ack_port", {254'd0, bus.p1_ack_o, bus.p0_ack_o}, e.p ? 256'd2 : 256'd1);
          check("ack_data", e.p ? bus.p1_data_o : bus.p0_data_o, e.r);
          check("other_data_hold", e.p ? bus.p0_data_o : bus.p1_data_o, last_d[~e.p]);
          last_d[e.p] = e.r;
        end
      end
    end
  end

  initial begin
    logic ok;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs();
    rst_i = 1'b0;
    @(negedge clk_i);

    // 1: port 0 read
    issue(0, 0, 32'h100, '0); expect_txn(0, 0, 32'h100, '0);
    wait_ack(0);
    wait_idle();

    // 2: port 1 write, busy drops once the DONE cycle passes
    issue(1, 1, 32'h200, {32{8'hA5}}); expect_txn(1, 1, 32'h200, {32{8'hA5}});
    wait_ack(1);
    check("busy_after_ack", {255'd0, busy_o}, 256'd0);
    wait_idle();

    // 3: simultaneous held requests from a fresh reset
    do_reset();
    issue(0, 0, 32'h1000, '0); issue(0, 0, 32'h1040, '0); issue(0, 0, 32'h1080, '0);
    issue(1, 0, 32'h2000, '0);
`ifdef MEM_ARB_RR_EN
    expect_txn(0, 0, 32'h1000, '0); expect_txn(1, 0, 32'h2000, '0);
    expect_txn(0, 0, 32'h1040, '0); expect_txn(0, 0, 32'h1080, '0);
`else
    expect_txn(0, 0, 32'h1000, '0); expect_txn(0, 0, 32'h1040, '0);
    expect_txn(0, 0, 32'h1080, '0); expect_txn(1, 0, 32'h2000, '0);
`endif
    wait_idle();
    check("sb_drained", {224'd0, 32'(rq0.size() + rq1.size())}, 256'd0);

    // 4: requester changes address while BUSY
    issue(1, 0, 32'h300, '0); expect_txn(1, 0, 32'h300, '0);
    @(negedge clk_i);
    wait_grant();
    req_a[1] = 32'h400;
    ok = 1'b1;
    for (int k = 0; k < 200 && !bus.p1_ack_o; k++) begin
      if (bus.mem_addr_o !== 32'h300) ok = 1'b0;
      @(negedge clk_i);
    end
    check("addr_held", {255'd0, ok}, 256'd1);
    wait_idle();

    // 5: stalled memory raises the sticky timeout; late ack still completes
    mem_hold = 1'b1;
    issue(0, 0, 32'h500, '0); expect_txn(0, 0, 32'h500, '0);
    @(negedge clk_i);
    wait_grant();
    check("tmo_busy_c1", {255'd0, timeout_o}, 256'd0);
    repeat (63) @(negedge clk_i);
    check("tmo_busy_c64", {255'd0, timeout_o}, 256'd0);
    @(negedge clk_i);
    check("tmo_busy_c65", {255'd0, timeout_o}, 256'd1);
    repeat (10) @(negedge clk_i);
    check("tmo_sticky", {255'd0, timeout_o}, 256'd1);
    mem_hold = 1'b0;
    wait_idle();
    check("tmo_after_ack", {255'd0, timeout_o}, 256'd1);
    do_reset();
    check("tmo_cleared", {255'd0, timeout_o}, 256'd0);

    // 6: reset five cycles into BUSY, then a stray ack in IDLE
    issue(1, 0, 32'h600, '0); expect_txn(1, 0, 32'h600, '0);
    @(negedge clk_i);
    wait_grant();
    repeat (5) @(negedge clk_i);
    rst_i = 1'b1;
    req_en[1] = 1'b0; rq1.delete(); exp_q.delete();
    @(negedge clk_i);
    check_reset_outputs();
    rst_i = 1'b0;
    last_d[0] = '0; last_d[1] = '0;
    mem_force = 1'b1;
    @(negedge clk_i);
    mem_force = 1'b0;
    check("stray_ack_idle", {253'd0, busy_o, bus.p1_ack_o, bus.p0_ack_o}, 256'd0);
    repeat (3) @(negedge clk_i);
    check("stray_ack_later", {252'd0, bus.mem_enable_o, busy_o, bus.p1_ack_o, bus.p0_ack_o}, 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
